// File: rtl/alu_pipe_if.sv
// Handshake and payload bundle for alu_pipe: operand side (in_*) and result side (out_*).
`timescale 1ns/1ps
interface alu_pipe_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SEL_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [SEL_W-1:0] alu_sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_out;
  logic             flag_c;
  logic             flag_v;
  logic             flag_z;
  logic             flag_n;

  modport master (
    output in_valid, a, b, alu_sel, out_ready,
    input  in_ready, out_valid, alu_out, flag_c, flag_v, flag_z, flag_n
  );

  modport slave (
    input  in_valid, a, b, alu_sel, out_ready,
    output in_ready, out_valid, alu_out, flag_c, flag_v, flag_z, flag_n
  );
endinterface

// File: rtl/alu_pipe.sv
// Registered 16-op ALU with C/V/Z/N flags and a single-stage valid/ready output register.
`timescale 1ns/1ps
module alu_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SEL_W = 4
) (
  input logic       clk,
  input logic       rst,
  alu_pipe_if.slave bus
);

  localparam int unsigned MSB = WIDTH - 1;

  typedef enum logic [SEL_W-1:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NAND, OP_XOR, OP_NOT, OP_NOR,
    OP_XNOR, OP_INC, OP_ADC, OP_PASS_A, OP_PASS_B, OP_ZERO, OP_ONES, OP_REV
  } op_e;

  logic [WIDTH-1:0] res;
  logic [WIDTH:0]   sum;
  logic             carry;
  logic             ovf;
  logic             accept;

  // Single-stage pipe: a slot is free when empty or being drained this cycle.
  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    res   = '0;
    sum   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (op_e'(bus.alu_sel))
      OP_ADD: begin
        sum   = {1'b0, bus.a} + {1'b0, bus.b};
        res   = sum[MSB:0];
        carry = sum[WIDTH];
        ovf   = (bus.a[MSB] == bus.b[MSB]) && (res[MSB] != bus.a[MSB]);
      end
      OP_SUB: begin
        res   = bus.a - bus.b;
        carry = bus.a < bus.b;
        ovf   = (bus.a[MSB] != bus.b[MSB]) && (res[MSB] != bus.a[MSB]);
      end
      OP_AND:    res = bus.a & bus.b;
      OP_OR:     res = bus.a | bus.b;
      OP_NAND:   res = ~(bus.a & bus.b);
      OP_XOR:    res = bus.a ^ bus.b;
      OP_NOT:    res = ~bus.a;
      OP_NOR:    res = ~(bus.a | bus.b);
      OP_XNOR:   res = ~(bus.a ^ bus.b);
      // The implicit addend 1 has MSB 0, so overflow only from a positive a.
      OP_INC: begin
        sum   = {1'b0, bus.a} + (WIDTH+1)'(1);
        res   = sum[MSB:0];
        carry = sum[WIDTH];
        ovf   = !bus.a[MSB] && res[MSB];
      end
      OP_ADC: begin
        sum   = {1'b0, bus.a} + {1'b0, bus.b} + (WIDTH+1)'(1);
        res   = sum[MSB:0];
        carry = sum[WIDTH];
        ovf   = (bus.a[MSB] == bus.b[MSB]) && (res[MSB] != bus.a[MSB]);
      end
      OP_PASS_A: res = bus.a;
      OP_PASS_B: res = bus.b;
      OP_ZERO:   res = '0;
      OP_ONES:   res = '1;
      OP_REV: begin
        for (int i = 0; i < int'(WIDTH); i++) res[i] = bus.a[int'(MSB) - i];
      end
      default:   res = '0;
    endcase
  end

  // Result register: reset wins; on drain-only the payload is kept, only valid drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.alu_out   <= '0;
      bus.flag_c    <= 1'b0;
      bus.flag_v    <= 1'b0;
      bus.flag_z    <= 1'b0;
      bus.flag_n    <= 1'b0;
    end else if (accept) begin
      bus.out_valid <= 1'b1;
      bus.alu_out   <= res;
      bus.flag_c    <= carry;
      bus.flag_v    <= ovf;
      bus.flag_z    <= (res == '0);
      bus.flag_n    <= res[MSB];
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule
